// File: rtl/reg_bank_write_arbiter_if.sv
// Handshake and bank-write bundle for reg_bank_write_arbiter.
// Requesters A/B drive req/addr/data; the arbiter drives the bank side.
interface reg_bank_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                   req_a;
  logic [ADDR_W-1:0]      addr_a;
  logic [DATA_W-1:0]      data_a;
  logic                   done_a;
  logic                   req_b;
  logic [ADDR_W-1:0]      addr_b;
  logic [DATA_W-1:0]      data_b;
  logic                   done_b;
  logic [2**ADDR_W-1:0]   bank_we;
  logic [DATA_W-1:0]      bank_d;
  logic                   busy;

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    input  done_a, done_b,
    input  bank_we, bank_d, busy
  );

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    output done_a, done_b,
    output bank_we, bank_d, busy
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Two-requester write arbiter/sequencer for a flip-flop register bank.
// Optional ARB_FIXED_PRIO_EN: A always wins ties (default: round-robin).
module reg_bank_write_arbiter #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int HOLD_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  reg_bank_write_arbiter_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              win_b;
  logic              pick_b;
  logic [NREG-1:0]   we_q;
  logic [DATA_W-1:0] d_q;
  logic              done_a_q;
  logic              done_b_q;
  logic              busy_q;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_b;
`endif

  // Winner among requests pending this edge; a tie goes to A or round-robin.
  always_comb begin
    pick_b = bus.req_b & ~bus.req_a;
`ifndef ARB_FIXED_PRIO_EN
    if (bus.req_a & bus.req_b)
      pick_b = ~last_b;
`endif
  end

  // Sequencer: latch winner, hold the write enable, then acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      win_b    <= 1'b0;
      we_q     <= '0;
      d_q      <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_b   <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_a | bus.req_b) begin
            win_b  <= pick_b;
            d_q    <= pick_b ? bus.data_b : bus.data_a;
            we_q   <= NREG'(1) << (pick_b ? bus.addr_b : bus.addr_a);
            cnt    <= 4'(HOLD_CYCLES - 1);
            busy_q <= 1'b1;
            state  <= WRITE;
`ifndef ARB_FIXED_PRIO_EN
            last_b <= pick_b;
`endif
          end
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            we_q     <= '0;
            done_a_q <= ~win_b;
            done_b_q <= win_b;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          done_a_q <= 1'b0;
          done_b_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bank_we = we_q;
  assign bus.bank_d  = d_q;
  assign bus.done_a  = done_a_q;
  assign bus.done_b  = done_b_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter with a timeline model
// and literal spot checks.
module tb_reg_bank_write_arbiter;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_bank_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_bank_write_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: age = cycles since the sample edge of the current transaction
  // (-1 when idle). Write enable during ages 1..HOLD, done at HOLD+1.
  int          age = -1;
  logic        m_lastb = 1'b1;
  logic        m_winb = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_d = '0;
  logic        started = 1'b0;
  logic        pickb;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      age = -1;
      m_lastb = 1'b1;
      m_winb = 1'b0;
      m_d = '0;
    end else if (age < 0) begin
      if (bus.req_a || bus.req_b) begin
`ifdef ARB_FIXED_PRIO_EN
        pickb = !bus.req_a;
`else
        pickb = (bus.req_a && bus.req_b) ? !m_lastb : bus.req_b;
`endif
        m_lastb = pickb;
        m_winb = pickb;
        m_addr = pickb ? bus.addr_b : bus.addr_a;
        m_d = pickb ? bus.data_b : bus.data_a;
        age = 1;
      end
    end else begin
      age++;
      if (age > HOLD + 1) age = -1;
    end
  end

  logic [7:0] e_we;
  logic       e_da, e_db, e_busy;

  always @(negedge clk) begin
    if (started) begin
      e_we   = (age >= 1 && age <= HOLD) ? 8'(1 << m_addr) : 8'h00;
      e_da   = (age == HOLD + 1) && !m_winb;
      e_db   = (age == HOLD + 1) && m_winb;
      e_busy = (age >= 1);
      chk("model_we", 32'(bus.bank_we), 32'(e_we));
      chk("model_d", 32'(bus.bank_d), 32'(m_d));
      chk("model_done_a", 32'(bus.done_a), 32'(e_da));
      chk("model_done_b", 32'(bus.done_b), 32'(e_db));
      chk("model_busy", 32'(bus.busy), 32'(e_busy));
    end
  end

  logic        log_en = 1'b0;
  logic        we_seen = 1'b0;
  logic [7:0]  log_we[$];
  byte         log_win[$];

  always @(negedge clk) begin
    if (log_en) begin
      if (bus.done_a) log_win.push_back("A");
      if (bus.done_b) log_win.push_back("B");
      if (bus.bank_we != 0 && !we_seen) log_we.push_back(bus.bank_we);
      we_seen = (bus.bank_we != 0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  byte        exp_win[3];
  logic [7:0] exp_we[3];

  initial begin
    bus.req_a = 1'b1; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b1; bus.addr_b = '0; bus.data_b = '0;

    // reset with both requests high
    repeat (3) cyc();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.bank_we), 0);
    chk("rst_d", 32'(bus.bank_d), 0);
    rst = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    cyc();
    chk("idle_busy", 32'(bus.busy), 0);

    // single A write
    bus.req_a = 1'b1; bus.addr_a = 3'd5; bus.data_a = 8'h3C;
    cyc();
    chk("a_we1", 32'(bus.bank_we), 32'h20);
    chk("a_d1", 32'(bus.bank_d), 32'h3C);
    bus.req_a = 1'b0;
    cyc();
    chk("a_we2", 32'(bus.bank_we), 32'h20);
    cyc();
    chk("a_done", 32'(bus.done_a), 1);
    chk("a_we3", 32'(bus.bank_we), 0);
    chk("a_busy3", 32'(bus.busy), 1);
    cyc();
    chk("a_idle", 32'(bus.busy), 0);
    chk("a_dkeep", 32'(bus.bank_d), 32'h3C);

    // both held after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = 3'd1; bus.data_a = 8'h11;
    bus.req_b = 1'b1; bus.addr_b = 3'd6; bus.data_b = 8'h66;
    log_en = 1'b1;
    repeat (11) cyc();
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (2) cyc();
    log_en = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    exp_win = '{"A", "A", "A"};
    exp_we  = '{8'h02, 8'h02, 8'h02};
`else
    exp_win = '{"A", "B", "A"};
    exp_we  = '{8'h02, 8'h40, 8'h02};
`endif
    chk("rr_ndone", 32'(log_win.size()), 3);
    chk("rr_nwe", 32'(log_we.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_win.size())
        chk($sformatf("rr_win%0d", i), 32'(log_win[i]), 32'(exp_win[i]));
      if (i < log_we.size())
        chk($sformatf("rr_we%0d", i), 32'(log_we[i]), 32'(exp_we[i]));
    end

    // B latched, then inputs change and req drops
    bus.req_b = 1'b1; bus.addr_b = 3'd2; bus.data_b = 8'hAA;
    cyc();
    bus.addr_b = 3'd7; bus.data_b = 8'h55; bus.req_b = 1'b0;
    chk("b_we1", 32'(bus.bank_we), 32'h04);
    chk("b_d1", 32'(bus.bank_d), 32'hAA);
    cyc();
    chk("b_we2", 32'(bus.bank_we), 32'h04);
    chk("b_d2", 32'(bus.bank_d), 32'hAA);
    cyc();
    chk("b_done", 32'(bus.done_b), 1);
    cyc();

    // reset in second write cycle
    bus.req_a = 1'b1; bus.addr_a = 3'd3; bus.data_a = 8'h77;
    cyc();
    bus.req_a = 1'b0;
    chk("m_we1", 32'(bus.bank_we), 32'h08);
    cyc();
    rst = 1'b1;
    cyc();
    chk("m_we", 32'(bus.bank_we), 0);
    chk("m_busy", 32'(bus.busy), 0);
    chk("m_done", 32'({bus.done_a, bus.done_b}), 0);
    rst = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = 3'd4; bus.data_a = 8'h44;
    bus.req_b = 1'b1; bus.addr_b = 3'd0; bus.data_b = 8'h01;
    cyc();
    chk("m_grant_we", 32'(bus.bank_we), 32'h10);
    chk("m_grant_d", 32'(bus.bank_d), 32'h44);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    cyc();
    chk("m_nodone", 32'({bus.done_a, bus.done_b}), 0);
    cyc();
    chk("m_done_a", 32'(bus.done_a), 1);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
